// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer.
package debounce_pkg;

  // FSM states, exposed on the debug port of button_debouncer.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Bits needed to hold any value 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one synchronized button level and emits one-cycle PRESS, RELEASE,
// LONG and REPEAT event pulses alongside a clean LEVEL.
//
// Handshake: none. IN is sampled every rising CLK edge; every output is a
// register. Each pulse output is high for exactly one cycle. No backpressure.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   IN,
  output logic   LEVEL,
  output logic   PRESS,
  output logic   RELEASE,
  output logic   LONG,
  output logic   REPEAT,
  output state_t dbg_state
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = cnt_width(HMAX);

  // Terminal counts; the REPEAT one is unused when REPEAT_CYCLES is 0.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Next-state, counter and pulse logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN) begin
          state_d = DB_PRESS;
          dcnt_d  = '0;
        end
      end
      DB_PRESS: begin
        if (!IN) begin
          // Glitch: drop back without touching any output.
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d     = HELD;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!IN) begin
          // Hold time is frozen while a release is being debounced.
          state_d = DB_RELEASE;
          dcnt_d  = '0;
        end else if (!long_done_q) begin
          if (hcnt_q == L_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            hcnt_d      = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (REPEAT_CYCLES > 0) begin
          if (hcnt_q == R_LAST) begin
            repeat_d = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      DB_RELEASE: begin
        if (IN) begin
          // Bounce during release: resume the hold where it left off.
          state_d = HELD;
        end else if (dcnt_q == D_LAST) begin
          state_d     = IDLE;
          level_d     = 1'b0;
          release_d   = 1'b1;
          hcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LEVEL     = level_q;
  assign PRESS     = press_q;
  assign RELEASE   = release_q;
  assign LONG      = long_q;
  assign REPEAT    = repeat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing input,
// checked every cycle against a run-length reference model.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  // ---------------- clock / reset ----------------
  logic   CLK = 1'b0;
  logic   RST_N = 1'b0;
  logic   IN = 1'b0;

  always #5 CLK = ~CLK;

  logic   level_a, press_a, release_a, long_a, repeat_a;
  state_t state_a;
  logic   level_b, press_b, release_b, long_b, repeat_b;
  state_t state_b;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .IN(IN),
    .LEVEL(level_a), .PRESS(press_a), .RELEASE(release_a),
    .LONG(long_a), .REPEAT(repeat_a), .dbg_state(state_a)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(0)) u_dut_norep (
    .CLK(CLK), .RST_N(RST_N), .IN(IN),
    .LEVEL(level_b), .PRESS(press_b), .RELEASE(release_b),
    .LONG(long_b), .REPEAT(repeat_b), .dbg_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];   // expected REPEAT edge numbers
  bit track_rep = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A change is accepted after D+1 consecutive samples disagreeing with the
  // debounced level. Hold time counts stable pressed samples; LONG at L,
  // REPEAT every R beyond that.
  logic m_level;
  int   m_streak, m_held;
  logic e_press, e_release, e_long, e_rep;

  task automatic model_reset();
    m_level = 0; m_streak = 0; m_held = 0;
    e_press = 0; e_release = 0; e_long = 0; e_rep = 0;
  endtask

  task automatic model_step(input logic v);
    e_press = 0; e_release = 0; e_long = 0; e_rep = 0;
    if (v != m_level) begin
      m_streak++;
      if (m_streak == D + 1) begin
        m_level = v;
        m_streak = 0;
        m_held = 0;
        if (v) e_press = 1; else e_release = 1;
      end
    end else begin
      if (m_level && m_streak == 0) begin
        m_held++;
        if (m_held == L) e_long = 1;
        else if (m_held > L && ((m_held - L) % R) == 0) e_rep = 1;
      end
      m_streak = 0;
    end
  endtask

  // ---------------- event log ----------------
  int edge_no = 0;
  int press_edge, long_edge, long_b_edge, rel_edge;
  int press_cnt, long_cnt, rep_cnt, rel_cnt, rep_b_cnt;

  task automatic clear_log();
    press_edge = -1; long_edge = -1; long_b_edge = -1; rel_edge = -1;
    press_cnt = 0; long_cnt = 0; rep_cnt = 0; rel_cnt = 0; rep_b_cnt = 0;
    exp_q.delete();
  endtask

  task automatic compare_all();
    check("level",     level_a,   m_level);
    check("press",     press_a,   e_press);
    check("release",   release_a, e_release);
    check("long",      long_a,    e_long);
    check("repeat",    repeat_a,  e_rep);
    check("level_nr",  level_b,   m_level);
    check("press_nr",  press_b,   e_press);
    check("release_nr",release_b, e_release);
    check("long_nr",   long_b,    e_long);
    check("repeat_nr", repeat_b,  1'b0);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives IN, lets one rising edge pass, checks.
  task automatic step(input logic v);
    IN = v;
    @(posedge CLK);
    model_step(v);
    edge_no++;
    @(negedge CLK);
    compare_all();
    if (press_a)   begin press_cnt++; press_edge = edge_no; end
    if (release_a) begin rel_cnt++;   rel_edge = edge_no;   end
    if (long_a)    begin long_cnt++;  long_edge = edge_no;  end
    if (long_b)    long_b_edge = edge_no;
    if (repeat_b)  rep_b_cnt++;
    if (repeat_a) begin
      rep_cnt++;
      if (track_rep) begin
        if (exp_q.size() == 0) check("repeat_unexpected", edge_no, 0);
        else check("repeat_edge", edge_no, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_level"}, {level_a, level_b}, 2'b00);
    check({tag, "_pulses"}, {press_a, release_a, long_a, repeat_a,
                             press_b, release_b, long_b, repeat_b}, 8'h00);
    check({tag, "_state"}, state_a, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, j;
    logic v;
    model_reset();
    clear_log();

    // Reset held with the button pressed: outputs stay low.
    IN = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle_outputs("in_reset");

    // Power-on held button: press after a full debounce, then LONG and REPEATs.
    RST_N = 1'b1;
    model_reset();
    k = edge_no + 1;
    track_rep = 1;
    for (int i = 0; i < 5; i++) exp_q.push_back(k + 17 + 3 * i);
    for (int i = 0; i < 30; i++) step(1'b1);
    check("press_edge", press_edge, k + 4);
    check("long_edge", long_edge, k + 14);
    check("long_count", long_cnt, 1);
    check("repeat_count", rep_cnt, 5);
    check("repeat_pending", exp_q.size(), 0);
    check("no_release", rel_cnt, 0);
    track_rep = 0;

    // Release bounce: short low burst is ignored, then a real release.
    clear_log();
    step(1'b0); step(1'b0); step(1'b1);
    check("bounce_no_release", rel_cnt, 0);
    check("bounce_level", level_a, 1'b1);
    j = edge_no + 1;
    for (int i = 0; i < 6; i++) step(1'b0);
    check("release_edge", rel_edge, j + 4);
    check("release_level", level_a, 1'b0);

    // Press glitch: three high samples then low stays invisible.
    clear_log();
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    check("glitch_press", press_cnt, 0);
    check("glitch_state", state_a, IDLE);
    check("glitch_state_nr", state_b, IDLE);

    // Asynchronous reset mid-cycle while held after LONG.
    clear_log();
    for (int i = 0; i < 16; i++) step(1'b1);
    check("pre_reset_long", long_cnt, 1);
    RST_N = 1'b0;
    #2;
    check_idle_outputs("async_reset");
    #1;
    RST_N = 1'b1;
    model_reset();
    clear_log();
    k = edge_no + 1;
    for (int i = 0; i < 5; i++) step(1'b1);
    check("reset_repress_edge", press_edge, k + 4);
    check("reset_no_release", rel_cnt, 0);

    // REPEAT disabled instance: long hold gives LONG only.
    for (int i = 0; i < 6; i++) step(1'b0);
    clear_log();
    k = edge_no + 1;
    for (int i = 0; i < 40; i++) step(1'b1);
    check("norep_long_edge", long_b_edge, k + 14);
    check("norep_repeat_count", rep_b_cnt, 0);

    // Random bouncing input with a mix of short glitches and long holds.
    v = 1'b0;
    for (int n = 0; n < 120; n++) begin
      int len;
      v = ~v;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(12, 30);
      else len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
